// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard sequencer state and the bundled
// stage-register control word used by the datapath top.
package rv32i_types;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_DONE = 2'd1,
        D_DONE = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_load;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_HOLD = '{
        pc_load: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b0, load_ex_mem: 1'b0,
        load_mem_wb: 1'b0, flush_if_id: 1'b0, flush_id_ex: 1'b0
    };

    localparam stage_ctrl_t CTRL_ADVANCE = '{
        pc_load: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0
    };

    localparam stage_ctrl_t CTRL_SQUASH = '{
        pc_load: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, flush_if_id: 1'b1, flush_id_ex: 1'b1
    };

    // Hold PC and IF/ID, push a NOP into EX, let the older stages drain.
    localparam stage_ctrl_t CTRL_BUBBLE = '{
        pc_load: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b1
    };

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in ID that needs the result of a load still in EX.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use
);

    // x0 never carries a real dependency, so a load targeting it needs no bubble.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: cache-miss freeze with
// response banking, load-use bubbles, mispredict squash, stall statistics.
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        br_mispredict,
    output logic        pc_load,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        cur_stall,
    output logic [31:0] stall_cycles,
    output logic        timeout
);

    hz_state_t         state, state_next;
    stage_ctrl_t       ctrl;
    logic              load_use;
    logic              i_ok, d_ok, freeze;
    logic [CNT_W-1:0]  wait_cnt;

    load_use_detect u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    // A banked response counts as ready until the other side catches up.
    assign i_ok   = imem_resp || (state == I_DONE);
    assign d_ok   = !dmem_req || dmem_resp || (state == D_DONE);
    assign freeze = !(i_ok && d_ok);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ctrl      = CTRL_HOLD;
        cur_stall = 1'b0;
        if (rst) begin
            ctrl = CTRL_HOLD;
        end else if (freeze) begin
            cur_stall = 1'b1;
        end else if (br_mispredict) begin
            ctrl = CTRL_SQUASH;
        end else if (load_use) begin
            ctrl = CTRL_BUBBLE;
        end else begin
            ctrl = CTRL_ADVANCE;
        end
    end

    assign pc_load     = ctrl.pc_load;
    assign load_if_id  = ctrl.load_if_id;
    assign load_id_ex  = ctrl.load_id_ex;
    assign load_ex_mem = ctrl.load_ex_mem;
    assign load_mem_wb = ctrl.load_mem_wb;
    assign flush_if_id = ctrl.flush_if_id;
    assign flush_id_ex = ctrl.flush_id_ex;

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (freeze && imem_resp)
                    state_next = I_DONE;
                else if (freeze && dmem_req && dmem_resp)
                    state_next = D_DONE;
            end
            I_DONE:  if (d_ok) state_next = RUN;
            D_DONE:  if (i_ok) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            timeout      <= 1'b0;
        end else begin
            state <= state_next;
            if (freeze) begin
                if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + 1'b1;
                stall_cycles <= stall_cycles + 32'd1;
                if (wait_cnt == CNT_W'(MAX_WAIT - 1))
                    timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a per-cycle reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    // {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, cur_stall}
    localparam logic [7:0] V_RESET  = 8'h00;
    localparam logic [7:0] V_FREEZE = 8'h01;
    localparam logic [7:0] V_RUN    = 8'hF8;
    localparam logic [7:0] V_SQUASH = 8'hFE;
    localparam logic [7:0] V_BUBBLE = 8'h3A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        ex_is_load = 1'b0, br_mispredict = 1'b0;
    logic        pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, cur_stall, timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.CNT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_is_load    (ex_is_load),
        .br_mispredict (br_mispredict),
        .pc_load       (pc_load),
        .load_if_id    (load_if_id),
        .load_id_ex    (load_id_ex),
        .load_ex_mem   (load_ex_mem),
        .load_mem_wb   (load_mem_wb),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .cur_stall     (cur_stall),
        .stall_cycles  (stall_cycles),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    wire [7:0] act_ctrl = {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                           flush_if_id, flush_id_ex, cur_stall};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which responses have arrived for the instruction pair
    // currently waiting, how long the current freeze has lasted, totals.
    logic        m_valid = 1'b0;
    logic        m_have_i = 1'b0, m_have_d = 1'b0;
    int          m_run = 0;
    logic [31:0] m_stalls = '0;
    logic        m_timeout = 1'b0;

    function automatic logic model_freeze();
        logic fetch_ready, data_ready;
        fetch_ready = imem_resp || m_have_i;
        data_ready  = !dmem_req || dmem_resp || m_have_d;
        return !(fetch_ready && data_ready);
    endfunction

    function automatic logic [7:0] model_ctrl();
        logic dep;
        dep = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (rst)           return V_RESET;
        if (model_freeze()) return V_FREEZE;
        if (br_mispredict) return V_SQUASH;
        if (dep)           return V_BUBBLE;
        return V_RUN;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b1;
            m_have_i  <= 1'b0;
            m_have_d  <= 1'b0;
            m_run     <= 0;
            m_stalls  <= '0;
            m_timeout <= 1'b0;
        end else if (model_freeze()) begin
            m_run    <= m_run + 1;
            m_stalls <= m_stalls + 32'd1;
            if (m_run + 1 >= MAX_WAIT) m_timeout <= 1'b1;
            m_have_i <= m_have_i | imem_resp;
            m_have_d <= m_have_d | (dmem_req & dmem_resp);
        end else begin
            m_run    <= 0;
            m_have_i <= 1'b0;
            m_have_d <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ctrl", 32'(act_ctrl), 32'(model_ctrl()));
            check("stall_cycles", stall_cycles, m_stalls);
            check("timeout", 32'(timeout), 32'(m_timeout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_is_load = 1'b0; br_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);

        // Hit stream
        for (int i = 0; i < 5; i++) begin
            #1 check("hit_ctrl", 32'(act_ctrl), 32'(V_RUN));
            tick();
        end
        check("hit_stall_cycles", stall_cycles, 32'd0);

        // Split miss: fetch returns in cycle 2, data in cycle 6
        do_reset();
        dmem_req = 1'b1; imem_resp = 1'b0;
        #1 check("split_c1_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        imem_resp = 1'b1;
        tick();
        imem_resp = 1'b0;
        tick(); tick(); tick();
        dmem_resp = 1'b1;
        #1 check("split_c6_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();
        check("split_stall_cycles", stall_cycles, 32'd5);
        check("split_timeout", 32'(timeout), 32'd1);
        idle_inputs();
        #1 check("split_after_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();

        // A repeated fetch pulse while already banked must not release the freeze
        dmem_req = 1'b1; imem_resp = 1'b1;
        tick();
        #1 check("repeat_i_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        imem_resp = 1'b0; dmem_resp = 1'b1;
        #1 check("repeat_i_release", 32'(act_ctrl), 32'(V_RUN));
        tick();

        // Both responses together: no banking left behind
        imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        #1 check("both_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();
        dmem_resp = 1'b0;
        #1 check("both_next_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        dmem_resp = 1'b1;
        tick();
        idle_inputs();

        // Load-use
        do_reset();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
        #1 check("lu_rs2_ctrl", 32'(act_ctrl), 32'(V_BUBBLE));
        tick();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1 check("lu_x0_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1;
        #1 check("lu_rs1_ctrl", 32'(act_ctrl), 32'(V_BUBBLE));
        tick();
        ex_is_load = 1'b0;
        #1 check("lu_not_load_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();

        // Mispredict overrides load-use; freeze overrides mispredict
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; br_mispredict = 1'b1;
        #1 check("mp_lu_ctrl", 32'(act_ctrl), 32'(V_SQUASH));
        tick();
        imem_resp = 1'b0;
        #1 check("mp_freeze_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        idle_inputs();
        tick();

        // Watchdog: fetch withheld for 6 cycles
        do_reset();
        imem_resp = 1'b0;
        tick(); tick(); tick();
        check("wd_before", 32'(timeout), 32'd0);
        tick();
        check("wd_rise", 32'(timeout), 32'd1);
        tick(); tick();
        imem_resp = 1'b1;
        tick(); tick();
        check("wd_sticky", 32'(timeout), 32'd1);
        check("wd_stall_cycles", stall_cycles, 32'd6);
        rst = 1'b1;
        tick();
        check("wd_cleared", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Reset while a data response is banked
        idle_inputs();
        imem_resp = 1'b0; dmem_req = 1'b1; dmem_resp = 1'b1;
        #1 check("dd_bank_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        rst = 1'b1; dmem_resp = 1'b0;
        #1 check("dd_reset_ctrl", 32'(act_ctrl), 32'(V_RESET));
        tick();
        rst = 1'b0; imem_resp = 1'b1;
        #1 check("dd_lost_ctrl", 32'(act_ctrl), 32'(V_FREEZE));
        tick();
        imem_resp = 1'b0; dmem_resp = 1'b1;
        #1 check("dd_release_ctrl", 32'(act_ctrl), 32'(V_RUN));
        tick();
        idle_inputs();
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC register. It freezes the pipeline on instruction-cache and data-cache misses, and tracks which cache has already responded so each response is consumed exactly once. It also inserts load-use bubbles, squashes wrong-path instructions on branch mispredict, and keeps stall/watchdog statistics.

Parameters:
CNT_W, 8, width of the consecutive-freeze watchdog counter
MAX_WAIT, 200, number of consecutive freeze cycles after which timeout asserts (must be below 2**CNT_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_resp  in  1  single-cycle pulse: fetch data valid this cycle
dmem_req  in  1  level: instruction in MEM stage has rmask or wmask nonzero
dmem_resp  in  1  single-cycle pulse: data access complete
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
ex_rd  in  5  rd of instruction in EX
ex_is_load  in  1  instruction in EX is a load
br_mispredict  in  1  EX resolved a taken branch/jump (level, held while EX is frozen)
pc_load  out  1  PC register load enable
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage register load enables
flush_if_id, flush_id_ex  out  1 each  when high with the matching load, the register captures all-zero (NOP) instead of its input
cur_stall  out  1  pipeline frozen this cycle (feeds cur_stall_in of MEM/WB)
stall_cycles  out  32  count of frozen cycles, wraps at 2**32
timeout  out  1  sticky watchdog flag

Behaviour:
- FSM states:
  - RUN: no response banked.
  - I_DONE: fetch response banked, waiting on data.
  - D_DONE: data response banked, waiting on fetch.
- Readiness and freeze:
  - i_ok = imem_resp | (state==I_DONE).
  - d_ok = ~dmem_req | dmem_resp | (state==D_DONE).
  - freeze = ~(i_ok & d_ok); advance = ~freeze.
- Outputs are combinational, evaluated in priority order:
  - rst: all load, pc_load, flush and cur_stall outputs are 0.
  - freeze: all loads 0, pc_load 0, flushes 0, cur_stall 1.
  - br_mispredict: all loads 1, pc_load 1, flush_if_id 1, flush_id_ex 1. Any load-use condition is ignored, since the dependent instruction is squashed.
  - load_use = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2): pc_load 0, load_if_id 0, load_id_ex 1 with flush_id_ex 1, load_ex_mem 1, load_mem_wb 1.
  - otherwise: all loads 1, pc_load 1, flushes 0.
- FSM transitions (registered):
  - RUN to I_DONE: freeze & imem_resp.
  - RUN to D_DONE: freeze & dmem_req & dmem_resp.
  - I_DONE to RUN: on d_ok.
  - D_DONE to RUN: on i_ok.
  - Both responses in the same cycle: no freeze, stay in RUN.
  - A second imem_resp while in I_DONE, or dmem_resp while in D_DONE, is ignored and does not advance.
- Watchdog:
  - wait_cnt (CNT_W bits) increments on each freeze cycle, saturating at 2**CNT_W-1, and clears on advance.
  - timeout sets when freeze & wait_cnt==MAX_WAIT-1, and holds until rst.
- stall_cycles increments on every freeze cycle, including cycles after timeout.
- Reset:
  - Values: state RUN, wait_cnt 0, stall_cycles 0, timeout 0.
  - Reset mid-miss discards any banked response; the next cycle re-evaluates from RUN.
- Latency: zero. Controls for the edge ending cycle N depend only on cycle-N inputs and the registered state.

Decomposition:
- Add to rv32i_types: enum hz_state_t {RUN, I_DONE, D_DONE} and a packed struct stage_ctrl_t {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}, for use by the datapath top.
- One sub-module, load_use_detect: purely combinational, taking id_rs1, id_rs2, ex_rd and ex_is_load and producing load_use.
- FSM and counters stay in the top block.

Test Plan:
- Hit stream: imem_resp=1 every cycle, dmem_req=0 → all loads 1 every cycle; cur_stall 0; stall_cycles stays 0.
- Split miss: dmem_req=1, imem_resp at cycle 2, dmem_resp at cycle 6 → state I_DONE for cycles 3-6; freeze and cur_stall=1 for cycles 1-5; advance at cycle 6; stall_cycles=5.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5 → pc_load=0, load_if_id=0, flush_id_ex=1, other loads 1. Repeat with ex_rd=0 → no bubble.
- Mispredict plus load-use in the same cycle → flush_if_id=1, flush_id_ex=1, pc_load=1, no load_if_id hold.
- Watchdog: MAX_WAIT=4, imem_resp held 0 for 6 cycles → timeout rises at cycle 4 and stays 1 after imem_resp returns; cleared only by rst.
- Reset in D_DONE, then imem_resp with dmem_req=1 and no dmem_resp → pipeline freezes again (the banked data response is lost).
